// File: rtl/pmem_arbiter_if.sv
// Requester and physical-memory bus bundle for pmem_arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface pmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    logic              l2_pmem_read;
    logic [ADDR_W-1:0] l2_pmem_raddress;
    logic [LINE_W-1:0] l2_pmem_rdata;
    logic              l2_pmem_resp;

    logic              ewb_pmem_write;
    logic [ADDR_W-1:0] ewb_pmem_address;
    logic [LINE_W-1:0] ewb_pmem_wdata;
    logic              ewb_pmem_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  l2_pmem_read, l2_pmem_raddress,
        input  ewb_pmem_write, ewb_pmem_address, ewb_pmem_wdata,
        input  pmem_rdata, pmem_resp,
        output l2_pmem_rdata, l2_pmem_resp, ewb_pmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output l2_pmem_read, l2_pmem_raddress,
        output ewb_pmem_write, ewb_pmem_address, ewb_pmem_wdata,
        output pmem_rdata, pmem_resp,
        input  l2_pmem_rdata, l2_pmem_resp, ewb_pmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/pmem_arbiter.sv
// Physical-memory port arbiter between the L2 fill path (reads) and the EWB (writes).
// Reads win by default; writes win on a same-line hazard or after STARVE_LIMIT read grants.
module pmem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int LINE_W       = 128,
    parameter int OFFSET_BITS  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic           clk,
    input logic           reset,
    pmem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              pmem_read_q, pmem_read_d;
    logic              pmem_write_q, pmem_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              same_line;
    logic              starved;

    assign same_line = (bus.l2_pmem_raddress >> OFFSET_BITS) ==
                       (bus.ewb_pmem_address >> OFFSET_BITS);
    assign starved   = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            IDLE: begin
                // A pending write must land before a read of the same line
                if (bus.ewb_pmem_write && (!bus.l2_pmem_read || same_line || starved)) begin
                    state_d      = WRITE;
                    addr_d       = bus.ewb_pmem_address;
                    wdata_d      = bus.ewb_pmem_wdata;
                    starve_cnt_d = '0;
                end else if (bus.l2_pmem_read) begin
                    state_d = READ;
                    addr_d  = bus.l2_pmem_raddress;
                    if (bus.ewb_pmem_write && !starved) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end
            end
            READ, WRITE: begin
                if (bus.pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        pmem_read_d  = (state_d == READ);
        pmem_write_d = (state_d == WRITE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign bus.pmem_read     = pmem_read_q;
    assign bus.pmem_write    = pmem_write_q;
    assign bus.pmem_address  = addr_q;
    assign bus.pmem_wdata    = wdata_q;
    // Completion is routed in the same cycle; an aborting reset suppresses it
    assign bus.l2_pmem_resp  = bus.pmem_resp && (state_q == READ) && !reset;
    assign bus.ewb_pmem_resp = bus.pmem_resp && (state_q == WRITE) && !reset;
    assign bus.l2_pmem_rdata = bus.pmem_rdata;
endmodule
